// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and sizing helper for counter blocks
package counter_pkg;

  localparam logic CNT_DIR_DOWN = 1'b0;
  localparam logic CNT_DIR_UP   = 1'b1;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Bits needed to hold 0..n-1, never less than one so registers stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides enabled cycles into one step every PRESCALE
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int            PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be >= 1");
  end

  logic [PW-1:0] pre_cnt;

  // With PRESCALE=1 LAST is 0, so pre_cnt never leaves 0 and step equals en.
  assign step = en && (pre_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (step) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/counter_up_down_param.sv
// rtl/counter_up_down_param.sv - up/down counter with modulus, wrap/saturate, load and prescaler
module counter_up_down_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_count,
  output logic             at_limit,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 1) begin : g_bad_width
    $error("counter_up_down_param: WIDTH must be >= 1");
  end
  if (MAX_VAL < 1) begin : g_bad_max_low
    $error("counter_up_down_param: MAX_VAL must be >= 1");
  end
  if (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max_high
    $error("counter_up_down_param: MAX_VAL exceeds 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_up_down_param: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic             SAT_ON  = (SATURATE == CNT_MODE_SAT);

  logic             step;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_next;
  logic             sat_next;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  // Limits are compared explicitly so a modulus below 2**WIDTH-1 never
  // depends on natural overflow.
  always_comb begin
    cnt_next  = bin_count;
    wrap_next = 1'b0;
    sat_next  = 1'b0;
    if (load) begin
      cnt_next = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (step) begin
      if (up_down == CNT_DIR_UP) begin
        if (bin_count < MAX_C) begin
          cnt_next = bin_count + ONE;
        end else if (SAT_ON) begin
          sat_next = 1'b1;
        end else begin
          cnt_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (bin_count != '0) begin
          cnt_next = bin_count - ONE;
        end else if (SAT_ON) begin
          sat_next = 1'b1;
        end else begin
          cnt_next  = MAX_C;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_count <= '0;
      wrap      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      bin_count <= cnt_next;
      wrap      <= wrap_next;
      sat       <= sat_next;
    end
  end

  assign at_limit = (up_down == CNT_DIR_UP) ? (bin_count == MAX_C) : (bin_count == '0);

endmodule
